pixel_to_hex: RTL and testbench

- Converts the raster pixel coordinate stream into hexagonal polar coordinates: a sector index 0–5 and a hexagonal radius.
- Sits directly upstream of the hex-coordinate-to-colour stage. Its `quadrant` and `radius` outputs feed that stage unmodified.
- Implemented as a fixed 3-stage pipeline. It accepts one pixel per clock with no backpressure.
- Applies an optional per-frame sector rotation for the spinning playfield.

---
 rtl/pixel_to_hex.sv | 95 +++++++++
 tb/tb_pixel_to_hex.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_to_hex.sv
// pixel_to_hex: 3-stage raster-to-hex-polar pipeline (sector 0..5, radius); rotation under PIXEL_TO_HEX_ROTATE_EN
module pixel_to_hex #(
  parameter int CX = 320,
  parameter int CY = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       frame_start,
  input  logic [2:0] rot,
  output logic       hex_valid,
  output logic [2:0] quadrant,
  output logic [9:0] radius
);
  logic [10:0] dx, dy;
  logic        v1, v2, sx1, sy1, sx2, sy2, a2, a_next;
  logic [9:0]  ax1, ay1, ax2, rad;
  logic [18:0] ay_k, ax_k, sumb, sumb2;
  logic [2:0]  base, quad;
  assign dx = {1'b0, pix_x} - 11'(CX);
  assign dy = 11'(CY) - {1'b0, pix_y};
  assign ay_k = 19'(ay1) * 19'd443;
  assign ax_k = {1'b0, ax1, 8'b0};
  assign a_next = ay_k < ax_k;
  assign sumb = {2'b0, ax1, 7'b0} + 19'(ay1) * 19'd222;
  assign rad = a2 ? ax2 : (sumb2[18] ? 10'h3ff : sumb2[17:8]);
  assign base = sy2 ? (sx2 ? (a2 ? 3'd3 : 3'd4) : (a2 ? 3'd0 : 3'd5))
                    : (sx2 ? (a2 ? 3'd3 : 3'd2) : (a2 ? 3'd0 : 3'd1));
`ifdef PIXEL_TO_HEX_ROTATE_EN
  logic [2:0] rot_q, rot1, rot2, rot_eff, rot_n;
  logic [3:0] sum;
  assign rot_eff = frame_start ? rot : rot_q;
  assign rot_n = rot2 >= 3'd6 ? rot2 - 3'd6 : rot2;
  assign sum = {1'b0, base} + {1'b0, rot_n};
  assign quad = sum >= 4'd6 ? 3'(sum - 4'd6) : sum[2:0];
  // Per-frame rotation register and its copies travelling alongside each pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q <= '0;
      rot1 <= '0;
      rot2 <= '0;
    end else begin
      if (frame_start) rot_q <= rot;
      if (pix_valid) rot1 <= rot_eff;
      if (v1) rot2 <= rot1;
    end
  end
`else
  logic unused_rot;
  assign unused_rot = ^{frame_start, rot};
  assign quad = base;
`endif
  // Pipeline: abs/sign, 30-degree compare and hex-norm sum, then sector/radius outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      hex_valid <= 1'b0;
      ax1 <= '0;
      ay1 <= '0;
      sx1 <= 1'b0;
      sy1 <= 1'b0;
      a2 <= 1'b0;
      ax2 <= '0;
      sumb2 <= '0;
      sx2 <= 1'b0;
      sy2 <= 1'b0;
      quadrant <= '0;
      radius <= '0;
    end else begin
      v1 <= pix_valid;
      v2 <= v1;
      hex_valid <= v2;
      if (pix_valid) begin
        ax1 <= dx[10] ? 10'(-dx) : dx[9:0];
        ay1 <= dy[10] ? 10'(-dy) : dy[9:0];
        sx1 <= dx[10];
        sy1 <= dy[10];
      end
      if (v1) begin
        a2 <= a_next;
        ax2 <= ax1;
        sumb2 <= sumb;
        sx2 <= sx1;
        sy2 <= sy1;
      end
      if (v2) begin
        quadrant <= quad;
        radius <= rad;
      end
    end
  end
endmodule

// File: tb/tb_pixel_to_hex.sv
// tb_pixel_to_hex: directed and random checks of pixel_to_hex against a geometric reference model
module tb_pixel_to_hex;
  localparam int CX = 320;
  localparam int CY = 240;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       frame_start = 1'b0;
  logic [2:0] rot = '0;
  logic       hex_valid;
  logic [2:0] quadrant;
  logic [9:0] radius;
  int n_cmp = 0;
  int n_bad = 0;
  logic        mv0 = 0, mv1 = 0, ev = 0;
  logic [12:0] md0 = '0, md1 = '0;
  logic [2:0]  eq = '0;
  logic [9:0]  er = '0;
  int          mrot = 0;

  pixel_to_hex #(.CX(CX), .CY(CY)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .rot(rot), .hex_valid(hex_valid),
    .quadrant(quadrant), .radius(radius)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] ref_pix(input int x, input int y, input int rt);
    int dx, dy, ax, ay, r, q;
    bit near_x;
    dx = x - CX;
    dy = CY - y;
    ax = dx < 0 ? -dx : dx;
    ay = dy < 0 ? -dy : dy;
    near_x = ay * 443 < ax * 256;
    r = near_x ? ax : (ax * 128 + ay * 222) / 256;
    if (r > 1023) r = 1023;
    if (near_x) q = dx < 0 ? 3 : 0;
    else if (dy < 0) q = dx < 0 ? 4 : 5;
    else q = dx < 0 ? 2 : 1;
`ifdef PIXEL_TO_HEX_ROTATE_EN
    q = (q + rt % 6) % 6;
`endif
    return {3'(q), 10'(r)};
  endfunction

  task automatic step(input logic v, input int x, input int y, input logic fs, input int rt, input logic r);
    pix_valid = v;
    pix_x = 10'(x);
    pix_y = 10'(y);
    frame_start = fs;
    rot = 3'(rt);
    rst = r;
    @(posedge clk);
    if (r) begin
      mv0 = 0; mv1 = 0; ev = 0; eq = '0; er = '0; mrot = 0;
    end else begin
      ev = mv1;
      if (mv1) {eq, er} = md1;
      mv1 = mv0;
      md1 = md0;
      mv0 = v;
      if (v) md0 = ref_pix(x, y, fs ? rt : mrot);
      if (fs) mrot = rt;
    end
    #1;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 0, 1);
    step(1, 420, 240, 0, 0, 1);
    n_cmp++;
    if (hex_valid !== 1'b0 || quadrant !== 3'd0 || radius !== 10'd0) begin
      n_bad++;
      $display("FAIL reset: got v=%b q=%0d r=%0d want v=0 q=0 r=0", hex_valid, quadrant, radius);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_pixel(input string name, input int x, input int y, input int wq, input int wr);
    step(1, x, y, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b1 || quadrant !== 3'(wq) || radius !== 10'(wr)) begin
      n_bad++;
      $display("FAIL %s: got v=%b q=%0d r=%0d want v=1 q=%0d r=%0d", name, hex_valid, quadrant, radius, wq, wr);
    end
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b0 || quadrant !== 3'(wq) || radius !== 10'(wr)) begin
      n_bad++;
      $display("FAIL %s_hold: got v=%b q=%0d r=%0d want v=0 q=%0d r=%0d", name, hex_valid, quadrant, radius, wq, wr);
    end
  endtask

  task automatic test_back_to_back;
    step(1, 320, 140, 0, 0, 0);
    step(1, 220, 340, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b1 || quadrant !== 3'd1 || radius !== 10'd86) begin
      n_bad++;
      $display("FAIL b2b_first: got v=%b q=%0d r=%0d want v=1 q=1 r=86", hex_valid, quadrant, radius);
    end
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b1 || quadrant !== 3'd4 || radius !== 10'd136) begin
      n_bad++;
      $display("FAIL b2b_second: got v=%b q=%0d r=%0d want v=1 q=4 r=136", hex_valid, quadrant, radius);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rotation;
    int w5, w7;
`ifdef PIXEL_TO_HEX_ROTATE_EN
    w5 = 0;
    w7 = 2;
`else
    w5 = 1;
    w7 = 1;
`endif
    step(0, 0, 0, 1, 5, 0);
    step(1, 320, 140, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b1 || quadrant !== 3'(w5)) begin
      n_bad++;
      $display("FAIL rot5: got v=%b q=%0d want v=1 q=%0d", hex_valid, quadrant, w5);
    end
    step(1, 320, 140, 1, 7, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (hex_valid !== 1'b1 || quadrant !== 3'(w7)) begin
      n_bad++;
      $display("FAIL rot7_same_cycle: got v=%b q=%0d want v=1 q=%0d", hex_valid, quadrant, w7);
    end
    step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_midstream_reset;
    step(0, 0, 0, 1, 3, 0);
    step(1, 100, 100, 0, 0, 0);
    step(1, 500, 400, 0, 0, 0);
    step(1, 600, 50, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (hex_valid !== 1'b0 || quadrant !== 3'd0 || radius !== 10'd0) begin
        n_bad++;
        $display("FAIL midreset_quiet%0d: got v=%b q=%0d r=%0d want v=0 q=0 r=0", i, hex_valid, quadrant, radius);
      end
    end
    test_pixel("midreset_rot_cleared", 420, 240, 0, 100);
  endtask

  task automatic test_random;
    int x, y;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end else begin
        x = CX + $urandom_range(0, 80) - 40;
        y = CY + $urandom_range(0, 80) - 40;
      end
      step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 49) == 0, $urandom_range(0, 7),
           $urandom_range(0, 299) == 0);
      n_cmp++;
      if (hex_valid !== ev || quadrant !== eq || radius !== er) begin
        n_bad++;
        $display("FAIL random[%0d]: got v=%b q=%0d r=%0d want v=%b q=%0d r=%0d",
                 i, hex_valid, quadrant, radius, ev, eq, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pixel("east", 420, 240, 0, 100);
    test_back_to_back();
    test_pixel("saturate", 1023, 1023, 5, 1023);
    test_pixel("origin", 320, 240, 1, 0);
    test_pixel("equal_edge", 763, 496, 5, 443);
    test_pixel("west", 200, 250, 3, 120);
    test_rotation();
    test_midstream_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
